debug_read_axi: RTL and testbench

Host-side read port for the SpaceWire debug capture path, in the clock_50 domain. Buffers 14-bit debug words from the capture stage into a small FIFO. Returns them, plus status and overflow statistics, through a simplified AXI-style read channel (AR/R handshakes). This lets a host drain recovered-clock debug data without losing words between polls.

---
 rtl/debug_read_axi_if.sv | 20 ++
 rtl/debug_read_axi.sv | 163 ++++++++++++++++
 tb/tb_debug_read_axi.sv | 338 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/debug_read_axi_if.sv
// Simplified AXI-style read channel (AR/R) between a debug host and the capture read port.
interface debug_read_axi_if;
    logic [1:0]  araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;

    modport master (
        output araddr, arvalid, rready,
        input  arready, rdata, rresp, rvalid
    );

    modport slave (
        input  araddr, arvalid, rready,
        output arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/debug_read_axi.sv
// Host read port for the debug capture path: buffers captured words in a FIFO and
// returns data, status and overflow statistics over a simplified AR/R read channel.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// ST_IDLE   | arready high, waiting for an AR; response computed on accept
// ST_RESP   | rvalid high, rdata/rresp held until the host takes them
module debug_read_axi #(
    parameter int DATA_WIDTH = 14,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clock_50,
    input  logic                  reset_n,
    input  logic                  capture_valid,
    input  logic [DATA_WIDTH-1:0] data_stand,
    debug_read_axi_if.slave       bus
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_COUNT = (DEPTH_LOG2 + 1)'(DEPTH);

    typedef enum logic {
        ST_IDLE,
        ST_RESP
    } state_t;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, rd_ptr_q;
    logic [DEPTH_LOG2:0]   count_q;
    logic                  ovf_q;
    logic [7:0]            ovf_cnt_q;
    logic [31:0]           rdata_q;
    logic [1:0]            rresp_q;

    logic        accept;
    logic        full, empty;
    logic        push, drop, pop, clear;
    logic [31:0] status;
    logic [31:0] resp_data;
    logic [1:0]  resp_code;

    assign full  = (count_q == FULL_COUNT);
    assign empty = (count_q == '0);

    // A pop in the same cycle never frees room for a push: full means drop.
    assign push  = capture_valid && !full;
    assign drop  = capture_valid && full;
    assign pop   = accept && (bus.araddr == 2'd0) && !empty;
    assign clear = accept && (bus.araddr == 2'd2);

    always_ff @(posedge clock_50 or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.arvalid) begin
                    accept  = 1'b1;
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                if (bus.rready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign bus.arready = (state_q == ST_IDLE);
    assign bus.rvalid  = (state_q == ST_RESP);
    assign bus.rdata   = rdata_q;
    assign bus.rresp   = rresp_q;

    always_comb begin
        status                 = '0;
        status[DEPTH_LOG2:0]   = count_q;
        status[8]              = empty;
        status[9]              = full;
        status[10]             = ovf_q;
        status[23:16]          = ovf_cnt_q;
    end

    always_comb begin
        resp_data = '0;
        resp_code = 2'b00;
        case (bus.araddr)
            2'd0: begin
                if (empty) begin
                    resp_code = 2'b10;
                end else begin
                    resp_data = 32'(mem[rd_ptr_q]);
                end
            end
            2'd1, 2'd2: resp_data = status;
            default:    resp_code = 2'b10;
        endcase
    end

    always_ff @(posedge clock_50) begin
        if (push) begin
            mem[wr_ptr_q] <= data_stand;
        end
    end

    always_ff @(posedge clock_50 or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // A drop landing on the same cycle as a read-to-clear leaves one counted drop.
    always_ff @(posedge clock_50 or negedge reset_n) begin
        if (!reset_n) begin
            ovf_q     <= 1'b0;
            ovf_cnt_q <= '0;
        end else if (drop) begin
            ovf_q     <= 1'b1;
            if (clear) begin
                ovf_cnt_q <= 8'd1;
            end else if (ovf_cnt_q != 8'hFF) begin
                ovf_cnt_q <= ovf_cnt_q + 8'd1;
            end
        end else if (clear) begin
            ovf_q     <= 1'b0;
            ovf_cnt_q <= '0;
        end
    end

    always_ff @(posedge clock_50 or negedge reset_n) begin
        if (!reset_n) begin
            rdata_q <= '0;
            rresp_q <= 2'b00;
        end else if (accept) begin
            rdata_q <= resp_data;
            rresp_q <= resp_code;
        end
    end

endmodule

// File: tb/tb_debug_read_axi.sv
// Directed self-checking bench for debug_read_axi: FIFO order, status, overflow,
// back-pressure, push/pop collisions and asynchronous reset.
module tb_debug_read_axi;

    logic        clock_50;
    logic        reset_n;
    logic        capture_valid;
    logic [13:0] data_stand;

    int assertions = 0;
    int failures   = 0;

    debug_read_axi_if bus ();

    debug_read_axi #(
        .DATA_WIDTH (14),
        .DEPTH_LOG2 (4)
    ) dut (
        .clock_50      (clock_50),
        .reset_n       (reset_n),
        .capture_valid (capture_valid),
        .data_stand    (data_stand),
        .bus           (bus)
    );

    initial clock_50 = 1'b0;
    always #5 clock_50 = ~clock_50;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Issues one read with rready high; optionally strobes a capture in the accept cycle.
    // rv_ok reports that arready was seen and rvalid was high one cycle after accept.
    task automatic do_read(input logic [1:0] addr, input logic cap, input logic [13:0] cap_word,
                           output logic [31:0] data, output logic [1:0] resp, output logic rv_ok);
        int n;
        @(negedge clock_50);
        bus.araddr    = addr;
        bus.arvalid   = 1'b1;
        bus.rready    = 1'b1;
        capture_valid = cap;
        data_stand    = cap_word;
        n = 0;
        while (bus.arready !== 1'b1 && n < 20) begin
            @(negedge clock_50);
            capture_valid = 1'b0;
            n++;
        end
        @(posedge clock_50);
        @(negedge clock_50);
        bus.arvalid   = 1'b0;
        capture_valid = 1'b0;
        rv_ok = (bus.rvalid === 1'b1) && (n < 20);
        data  = bus.rdata;
        resp  = bus.rresp;
        @(posedge clock_50);
    endtask

    task automatic push_words(input int n, input logic [13:0] base);
        for (int i = 0; i < n; i++) begin
            @(negedge clock_50);
            capture_valid = 1'b1;
            data_stand    = base + 14'(i);
        end
        @(negedge clock_50);
        capture_valid = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        logic [1:0]  r;
        logic        ok;
        reset_n = 1'b0;
        repeat (3) @(negedge clock_50);
        assertions++;
        if (bus.rvalid !== 1'b0 || bus.arready !== 1'b1 || bus.rdata !== 32'h0 || bus.rresp !== 2'b00) begin
            failures++;
            $display("FAIL reset_outputs: rvalid=%b arready=%b rdata=%h rresp=%b, want 0 1 0 00",
                     bus.rvalid, bus.arready, bus.rdata, bus.rresp);
        end
        reset_n = 1'b1;
        do_read(2'd1, 1'b0, 14'h0, d, r, ok);
        assertions++;
        if (d !== 32'h0000_0100 || r !== 2'b00 || ok !== 1'b1) begin
            failures++;
            $display("FAIL reset_status: rdata=%h rresp=%b rv=%b, want 00000100 00 1", d, r, ok);
        end
    endtask

    task automatic test_fifo_order();
        logic [31:0] d;
        logic [1:0]  r;
        logic        ok;
        logic [13:0] words [3];
        words[0] = 14'h0001;
        words[1] = 14'h2ABC;
        words[2] = 14'h3FFF;
        for (int i = 0; i < 3; i++) begin
            push_words(1, words[i]);
        end
        for (int i = 0; i < 3; i++) begin
            do_read(2'd0, 1'b0, 14'h0, d, r, ok);
            assertions++;
            if (d !== {18'd0, words[i]} || r !== 2'b00 || ok !== 1'b1) begin
                failures++;
                $display("FAIL fifo_pop%0d: rdata=%h rresp=%b rv=%b, want %h 00 1", i, d, r, ok, words[i]);
            end
        end
        do_read(2'd0, 1'b0, 14'h0, d, r, ok);
        assertions++;
        if (d !== 32'h0 || r !== 2'b10) begin
            failures++;
            $display("FAIL fifo_empty_pop: rdata=%h rresp=%b, want 0 10", d, r);
        end
        do_read(2'd3, 1'b0, 14'h0, d, r, ok);
        assertions++;
        if (d !== 32'h0 || r !== 2'b10) begin
            failures++;
            $display("FAIL reserved_addr: rdata=%h rresp=%b, want 0 10", d, r);
        end
    endtask

    task automatic test_back_to_back();
        push_words(2, 14'h0111);
        @(negedge clock_50);
        bus.araddr  = 2'd0;
        bus.arvalid = 1'b1;
        bus.rready  = 1'b1;
        @(posedge clock_50);
        @(negedge clock_50);
        assertions++;
        if (bus.arready !== 1'b0 || bus.rvalid !== 1'b1 || bus.rdata !== 32'h0111) begin
            failures++;
            $display("FAIL b2b_first: arready=%b rvalid=%b rdata=%h, want 0 1 00000111",
                     bus.arready, bus.rvalid, bus.rdata);
        end
        @(negedge clock_50);
        assertions++;
        if (bus.arready !== 1'b1 || bus.rvalid !== 1'b0) begin
            failures++;
            $display("FAIL b2b_gap: arready=%b rvalid=%b, want 1 0", bus.arready, bus.rvalid);
        end
        @(negedge clock_50);
        bus.arvalid = 1'b0;
        assertions++;
        if (bus.rvalid !== 1'b1 || bus.rdata !== 32'h0112) begin
            failures++;
            $display("FAIL b2b_second: rvalid=%b rdata=%h, want 1 00000112", bus.rvalid, bus.rdata);
        end
        @(negedge clock_50);
    endtask

    task automatic test_overflow();
        logic [31:0] d;
        logic [1:0]  r;
        logic        ok;
        push_words(18, 14'h0100);
        do_read(2'd1, 1'b0, 14'h0, d, r, ok);
        assertions++;
        if (d !== 32'h0002_0610 || r !== 2'b00) begin
            failures++;
            $display("FAIL ovf_status: rdata=%h rresp=%b, want 00020610 00", d, r);
        end
        do_read(2'd2, 1'b0, 14'h0, d, r, ok);
        assertions++;
        if (d !== 32'h0002_0610 || r !== 2'b00) begin
            failures++;
            $display("FAIL ovf_clear_read: rdata=%h rresp=%b, want 00020610 00", d, r);
        end
        do_read(2'd1, 1'b0, 14'h0, d, r, ok);
        assertions++;
        if (d !== 32'h0000_0210) begin
            failures++;
            $display("FAIL ovf_after_clear: rdata=%h, want 00000210", d);
        end
        for (int i = 0; i < 16; i++) begin
            do_read(2'd0, 1'b0, 14'h0, d, r, ok);
            if (i == 0 || i == 15) begin
                assertions++;
                if (d !== 32'h0100 + 32'(i) || r !== 2'b00) begin
                    failures++;
                    $display("FAIL ovf_drain%0d: rdata=%h rresp=%b, want %h 00", i, d, r, 32'h0100 + 32'(i));
                end
            end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] d;
        logic [1:0]  r;
        logic        ok;
        push_words(1, 14'h0AAA);
        @(negedge clock_50);
        bus.araddr  = 2'd1;
        bus.arvalid = 1'b1;
        bus.rready  = 1'b0;
        @(posedge clock_50);
        for (int i = 0; i < 5; i++) begin
            @(negedge clock_50);
            bus.arvalid   = 1'b0;
            capture_valid = 1'b1;
            data_stand    = 14'h0B00 + 14'(i);
            assertions++;
            if (bus.rvalid !== 1'b1 || bus.arready !== 1'b0 || bus.rdata !== 32'h1 || bus.rresp !== 2'b00) begin
                failures++;
                $display("FAIL stall_cycle%0d: rvalid=%b arready=%b rdata=%h rresp=%b, want 1 0 00000001 00",
                         i, bus.rvalid, bus.arready, bus.rdata, bus.rresp);
            end
        end
        @(negedge clock_50);
        capture_valid = 1'b0;
        bus.rready    = 1'b1;
        @(negedge clock_50);
        assertions++;
        if (bus.rvalid !== 1'b0) begin
            failures++;
            $display("FAIL stall_release: rvalid=%b, want 0", bus.rvalid);
        end
        do_read(2'd1, 1'b0, 14'h0, d, r, ok);
        assertions++;
        if (d !== 32'h0000_0006) begin
            failures++;
            $display("FAIL stall_pushes_landed: rdata=%h, want 00000006", d);
        end
        do_read(2'd0, 1'b0, 14'h0, d, r, ok);
        assertions++;
        if (d !== 32'h0AAA) begin
            failures++;
            $display("FAIL stall_head: rdata=%h, want 00000aaa", d);
        end
    endtask

    task automatic test_push_pop_same();
        logic [31:0] d;
        logic [1:0]  r;
        logic        ok;
        do_read(2'd0, 1'b1, 14'h1234, d, r, ok);
        assertions++;
        if (d !== 32'h0B00 || r !== 2'b00) begin
            failures++;
            $display("FAIL pushpop_head: rdata=%h rresp=%b, want 00000b00 00", d, r);
        end
        do_read(2'd1, 1'b0, 14'h0, d, r, ok);
        assertions++;
        if (d !== 32'h0000_0005) begin
            failures++;
            $display("FAIL pushpop_count: rdata=%h, want 00000005", d);
        end
        push_words(11, 14'h0C00);
        do_read(2'd0, 1'b1, 14'h1555, d, r, ok);
        assertions++;
        if (d !== 32'h0B01 || r !== 2'b00) begin
            failures++;
            $display("FAIL full_pushpop_head: rdata=%h rresp=%b, want 00000b01 00", d, r);
        end
        do_read(2'd1, 1'b0, 14'h0, d, r, ok);
        assertions++;
        if (d !== 32'h0001_040F) begin
            failures++;
            $display("FAIL full_pushpop_drop: rdata=%h, want 0001040f", d);
        end
        push_words(1, 14'h0D00);
        do_read(2'd2, 1'b1, 14'h1666, d, r, ok);
        assertions++;
        if (d !== 32'h0001_0610) begin
            failures++;
            $display("FAIL clear_with_drop_read: rdata=%h, want 00010610", d);
        end
        do_read(2'd1, 1'b0, 14'h0, d, r, ok);
        assertions++;
        if (d !== 32'h0001_0610) begin
            failures++;
            $display("FAIL clear_with_drop_after: rdata=%h, want 00010610", d);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] d;
        logic [1:0]  r;
        logic        ok;
        for (int i = 0; i < 9; i++) begin
            do_read(2'd0, 1'b0, 14'h0, d, r, ok);
        end
        do_read(2'd1, 1'b0, 14'h0, d, r, ok);
        assertions++;
        if (d !== 32'h0001_0407) begin
            failures++;
            $display("FAIL pre_reset_status: rdata=%h, want 00010407", d);
        end
        @(negedge clock_50);
        bus.araddr  = 2'd1;
        bus.arvalid = 1'b1;
        bus.rready  = 1'b0;
        @(posedge clock_50);
        @(negedge clock_50);
        bus.arvalid = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        assertions++;
        if (bus.rvalid !== 1'b0 || bus.arready !== 1'b1 || bus.rdata !== 32'h0) begin
            failures++;
            $display("FAIL async_reset: rvalid=%b arready=%b rdata=%h, want 0 1 0",
                     bus.rvalid, bus.arready, bus.rdata);
        end
        repeat (2) @(negedge clock_50);
        reset_n    = 1'b1;
        bus.rready = 1'b1;
        do_read(2'd1, 1'b0, 14'h0, d, r, ok);
        assertions++;
        if (d !== 32'h0000_0100 || r !== 2'b00 || ok !== 1'b1) begin
            failures++;
            $display("FAIL post_reset_status: rdata=%h rresp=%b rv=%b, want 00000100 00 1", d, r, ok);
        end
    endtask

    initial begin
        reset_n       = 1'b0;
        capture_valid = 1'b0;
        data_stand    = '0;
        bus.araddr    = 2'd0;
        bus.arvalid   = 1'b0;
        bus.rready    = 1'b1;
        test_reset();
        test_fifo_order();
        test_back_to_back();
        test_overflow();
        test_backpressure();
        test_push_pop_same();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule
